// File: rtl/sync_event_arbiter.sv
// Synchronised, optionally debounced (SYNC_EVT_DEBOUNCE_EN) input levels whose changes become
// events, arbitrated round-robin onto a valid/ready port with a sticky lost-event flag.
module sync_event_arbiter #(
    parameter int unsigned       NUM_IN       = 4,
    parameter logic [NUM_IN-1:0] DEFAULT_OUT  = {NUM_IN{1'b0}},
    parameter int unsigned       PRESCALE     = 16,
    parameter int unsigned       DEBOUNCE_CNT = 3
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic [NUM_IN-1:0]         ivSignal,
    output logic [NUM_IN-1:0]         ovLevel,
    output logic                      oEvtValid,
    input  logic                      iEvtReady,
    output logic [$clog2(NUM_IN)-1:0] ovEvtIdx,
    output logic                      oEvtLevel,
    output logic                      oOverflow,
    input  logic                      iClrOvf
);
    localparam int unsigned IW = $clog2(NUM_IN);

    if (NUM_IN < 2 || NUM_IN > 16 || PRESCALE < 2 || PRESCALE > 65535 ||
        DEBOUNCE_CNT < 1 || DEBOUNCE_CNT > 15) begin : gBadCfg
        $error("sync_event_arbiter: parameter out of range");
    end

    logic [NUM_IN-1:0] syncMeta;
    logic [NUM_IN-1:0] syncLvl;
    logic [NUM_IN-1:0] levelNext;
    logic [NUM_IN-1:0] levelEvt;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            syncMeta <= DEFAULT_OUT;
            syncLvl  <= DEFAULT_OUT;
        end else begin
            syncMeta <= ivSignal;
            syncLvl  <= syncMeta;
        end
    end

`ifdef SYNC_EVT_DEBOUNCE_EN
    logic [15:0] preCnt;
    logic        tick;
    logic [3:0]  dbCnt [NUM_IN];

    always_comb tick = (preCnt == 16'(PRESCALE - 1));

    always_ff @(posedge iClk) begin
        if (iRst || tick) preCnt <= '0;
        else              preCnt <= preCnt + 16'd1;
    end

    // A tick that agrees with the current level restarts that input's stability count.
    always_ff @(posedge iClk) begin
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (iRst) begin
                dbCnt[i] <= '0;
            end else if (tick) begin
                if (syncLvl[i] == ovLevel[i] || dbCnt[i] == 4'(DEBOUNCE_CNT - 1))
                    dbCnt[i] <= '0;
                else
                    dbCnt[i] <= dbCnt[i] + 4'd1;
            end
        end
    end

    always_comb begin
        levelNext = ovLevel;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (tick && syncLvl[i] != ovLevel[i] && dbCnt[i] == 4'(DEBOUNCE_CNT - 1))
                levelNext[i] = syncLvl[i];
        end
    end
`else
    always_comb levelNext = syncLvl;
`endif

    always_ff @(posedge iClk) begin
        if (iRst) ovLevel <= DEFAULT_OUT;
        else      ovLevel <= levelNext;
    end

    // Events are taken from the next-level compare so pending is set on the same edge as ovLevel.
    always_comb levelEvt = levelNext ^ ovLevel;

    logic [NUM_IN-1:0] pending;
    logic [NUM_IN-1:0] evLvl;
    logic [NUM_IN-1:0] grantMask;
    logic [NUM_IN-1:0] pendingNext;
    logic [NUM_IN-1:0] ovfHit;
    logic [IW-1:0]     rrPtr;
    logic [IW-1:0]     winIdx;
    logic              winFound;
    logic              advance;

    always_comb begin
        winFound = 1'b0;
        winIdx   = '0;
        for (int unsigned k = 1; k <= NUM_IN; k++) begin
            if (!winFound && pending[(32'(rrPtr) + k) % NUM_IN]) begin
                winFound = 1'b1;
                winIdx   = IW'((32'(rrPtr) + k) % NUM_IN);
            end
        end
        advance   = !oEvtValid || iEvtReady;
        grantMask = '0;
        if (advance && winFound) grantMask[winIdx] = 1'b1;
        pendingNext = (pending & ~grantMask) | levelEvt;
        ovfHit      = pending & ~grantMask & levelEvt;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            pending   <= '0;
            evLvl     <= '0;
            oEvtValid <= 1'b0;
            ovEvtIdx  <= '0;
            oEvtLevel <= 1'b0;
            oOverflow <= 1'b0;
            rrPtr     <= IW'(NUM_IN - 1);
        end else begin
            pending <= pendingNext;
            evLvl   <= (evLvl & ~levelEvt) | (levelNext & levelEvt);
            if (advance) begin
                oEvtValid <= winFound;
                if (winFound) begin
                    ovEvtIdx  <= winIdx;
                    oEvtLevel <= evLvl[winIdx];
                    rrPtr     <= winIdx;
                end
            end
            if (|ovfHit)      oOverflow <= 1'b1;
            else if (iClrOvf) oOverflow <= 1'b0;
        end
    end
endmodule
